// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: machine widths, default reset PC,
// the NOP encoding used by decode on flush, and the FIFO entry layout.
package fetch_stage_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// Small synchronous FIFO of {pc, instr} entries. The head is readable in the
// cycle after the push, and reads as zero whenever the FIFO is empty.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem_reg [DEPTH];
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW:0]     count_reg;

    // Storage carries no reset; emptiness is tracked solely by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // DEPTH is a power of two, so the count MSB alone marks a full FIFO.
    assign full  = count_reg[AW];
    assign count = count_reg;
    assign head  = (count_reg != '0) ? mem_reg[rd_ptr_reg] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, addresses imem combinationally and
// queues {pc, instr} pairs for decode; an execute redirect flushes the queue.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    logic [XLEN-1:0]        pc_reg;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;
    fetch_entry_t           fifo_din;
    fetch_entry_t           fifo_head;

    // Redirect outranks both handshakes, so a flushed head is never consumed.
    assign pop  = if_valid & if_ready & ~redirect_valid;
    assign push = fetch_en & ~redirect_valid & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else if (redirect_valid) begin
            pc_reg <= align_pc(redirect_pc);
        end else if (push) begin
            pc_reg <= pc_reg + 32'd4;
        end
    end

    assign fifo_din.pc    = pc_reg;
    assign fifo_din.instr = imem_data;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign imem_addr = pc_reg;
    assign if_valid  = (fifo_count != '0);
    assign if_pc     = fifo_head.pc;
    assign if_instr  = fifo_head.instr;

endmodule
